// File: rtl/gpi_debounce.sv
// rtl/gpi_debounce.sv - multi-channel synchronised input debouncer with CSR-programmable filter time
module gpi_debounce #(
  parameter logic [4:0]            BASE_ADDR  = 5'h1d,
  parameter int                    NUM_INPUTS = 7,
  parameter logic [NUM_INPUTS-1:0] DFL_STATE  = {NUM_INPUTS{1'b0}},
  parameter logic [7:0]            DFL_TIME   = 8'd32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ce,
  input  logic [4:0]            csr_a,
  input  logic [7:0]            csr_di,
  input  logic                  csr_we,
  output logic [7:0]            csr_do,
  input  logic [NUM_INPUTS-1:0] in,
  output logic [NUM_INPUTS-1:0] out,
  output logic [NUM_INPUTS-1:0] out_posedge,
  output logic [NUM_INPUTS-1:0] out_negedge
);

  localparam logic [4:0] TIME_ADDR   = BASE_ADDR;
  localparam logic [4:0] BYPASS_ADDR = BASE_ADDR + 5'd1;

  logic [NUM_INPUTS-1:0]      sync1_q, sync1_d;
  logic [NUM_INPUTS-1:0]      sync2_q, sync2_d;
  logic [NUM_INPUTS-1:0]      out_q, out_d;
  logic [NUM_INPUTS-1:0]      pos_q, pos_d;
  logic [NUM_INPUTS-1:0]      neg_q, neg_d;
  logic [NUM_INPUTS-1:0][7:0] cnt_q, cnt_d;
  logic [7:0]                 time_q, time_d;
  logic [NUM_INPUTS-1:0]      bypass_q, bypass_d;
  logic                       time_we;
  logic                       bypass_we;
  logic [7:0]                 bypass_rd;

  // CSR write decode and next-value selection for the config registers
  always_comb begin
    time_we   = csr_we && (csr_a == TIME_ADDR);
    bypass_we = csr_we && (csr_a == BYPASS_ADDR);
    time_d    = time_we ? csr_di : time_q;
    bypass_d  = bypass_we ? csr_di[NUM_INPUTS-1:0] : bypass_q;
  end

  // Combinational CSR read; returns zero off-address so several blocks can be OR-ed onto one bus
  always_comb begin
    bypass_rd = 8'h00;
    bypass_rd[NUM_INPUTS-1:0] = bypass_q;
    csr_do = 8'h00;
    if (csr_a == TIME_ADDR) begin
      csr_do = time_q;
    end else if (csr_a == BYPASS_ADDR) begin
      csr_do = bypass_rd;
    end
  end

  // Per-channel synchroniser shift and stability filter with edge-strobe generation
  always_comb begin
    sync1_d = in;
    sync2_d = sync1_q;
    out_d   = out_q;
    cnt_d   = cnt_q;
    pos_d   = '0;
    neg_d   = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (time_we) begin
        // A new debounce time invalidates every partial count; levels hold.
        cnt_d[i] = 8'd0;
      end else if (sync2_q[i] == out_q[i]) begin
        cnt_d[i] = 8'd0;
      end else if ((time_q == 8'd0) || bypass_q[i]) begin
        // Unfiltered channel: follow the synchronised pin directly.
        out_d[i] = sync2_q[i];
        pos_d[i] = sync2_q[i];
        neg_d[i] = ~sync2_q[i];
        cnt_d[i] = 8'd0;
      end else if (ce && (cnt_q[i] == time_q - 8'd1)) begin
        out_d[i] = sync2_q[i];
        pos_d[i] = sync2_q[i];
        neg_d[i] = ~sync2_q[i];
        cnt_d[i] = 8'd0;
      end else if (ce) begin
        cnt_d[i] = cnt_q[i] + 8'd1;
      end
    end
  end

  // State registers; reset forces default levels so no strobe can appear on release
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q  <= DFL_STATE;
      sync2_q  <= DFL_STATE;
      out_q    <= DFL_STATE;
      pos_q    <= '0;
      neg_q    <= '0;
      cnt_q    <= '0;
      time_q   <= DFL_TIME;
      bypass_q <= '0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      out_q    <= out_d;
      pos_q    <= pos_d;
      neg_q    <= neg_d;
      cnt_q    <= cnt_d;
      time_q   <= time_d;
      bypass_q <= bypass_d;
    end
  end

  assign out         = out_q;
  assign out_posedge = pos_q;
  assign out_negedge = neg_q;

endmodule

// File: tb/tb_gpi_debounce.sv
// tb/tb_gpi_debounce.sv - directed self-checking bench for gpi_debounce
module tb_gpi_debounce;

  logic       clk = 1'b0;
  logic       rst;
  logic       ce;
  logic [4:0] csr_a;
  logic [7:0] csr_di;
  logic       csr_we;
  logic [7:0] csr_do;
  logic [6:0] in;
  logic [6:0] out;
  logic [6:0] out_posedge;
  logic [6:0] out_negedge;

  int checks   = 0;
  int failures = 0;

  gpi_debounce dut (
    .clk         (clk),
    .rst         (rst),
    .ce          (ce),
    .csr_a       (csr_a),
    .csr_di      (csr_di),
    .csr_we      (csr_we),
    .csr_do      (csr_do),
    .in          (in),
    .out         (out),
    .out_posedge (out_posedge),
    .out_negedge (out_negedge)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [6:0] eo, input logic [6:0] ep,
                         input logic [6:0] en);
    check({tag, " out"}, {1'b0, out}, {1'b0, eo});
    check({tag, " pos"}, {1'b0, out_posedge}, {1'b0, ep});
    check({tag, " neg"}, {1'b0, out_negedge}, {1'b0, en});
  endtask

  task automatic rd_check(input string tag, input logic [4:0] a, input logic [7:0] exp);
    csr_a = a;
    #1;
    check(tag, csr_do, exp);
    csr_a = 5'h00;
  endtask

  task automatic step(input logic c);
    ce = c;
    @(posedge clk);
    #1;
    ce = 1'b0;
  endtask

  task automatic csr_write(input logic [4:0] a, input logic [7:0] d);
    csr_a  = a;
    csr_di = d;
    csr_we = 1'b1;
    @(posedge clk);
    #1;
    csr_we = 1'b0;
    csr_a  = 5'h00;
    csr_di = 8'h00;
  endtask

  initial begin
    rst = 1'b1; ce = 1'b0; csr_a = 5'h00; csr_di = 8'h00; csr_we = 1'b0; in = 7'h7f;
    repeat (3) @(posedge clk);
    #1;
    chk_out("in_reset", 7'h00, 7'h00, 7'h00);
    rst = 1'b0;
    chk_out("reset_release", 7'h00, 7'h00, 7'h00);
    rd_check("reset_time", 5'h1d, 8'h20);
    rd_check("reset_bypass", 5'h1e, 8'h00);

    // default 32-tick filter on all channels going high
    step(1'b0); step(1'b0);
    for (int k = 0; k < 31; k++) begin
      step(1'b1);
      chk_out("dfl_wait", 7'h00, 7'h00, 7'h00);
    end
    step(1'b1);
    chk_out("dfl_rise", 7'h7f, 7'h7f, 7'h00);
    step(1'b0);
    chk_out("dfl_after", 7'h7f, 7'h00, 7'h00);

    // shorten filter and bring everything back low
    csr_write(5'h1d, 8'h04);
    rd_check("time4", 5'h1d, 8'h04);
    in = 7'h00;
    step(1'b0); step(1'b0);
    step(1'b1); step(1'b1); step(1'b1);
    chk_out("fall_wait", 7'h7f, 7'h00, 7'h00);
    step(1'b1);
    chk_out("fall", 7'h00, 7'h00, 7'h7f);
    step(1'b0);
    chk_out("fall_after", 7'h00, 7'h00, 7'h00);

    // clean press on channel 0, with a non-ce clock in the middle
    in = 7'h01;
    step(1'b0); step(1'b0);
    step(1'b1); step(1'b0); step(1'b1); step(1'b1);
    chk_out("press_wait", 7'h00, 7'h00, 7'h00);
    step(1'b1);
    chk_out("press_rise", 7'h01, 7'h01, 7'h00);
    step(1'b0);
    chk_out("press_after", 7'h01, 7'h00, 7'h00);

    // bounce on channel 1: one-clk low glitch restarts the count
    in = 7'h03;
    step(1'b0); step(1'b0);
    step(1'b1); step(1'b1); step(1'b1);
    in = 7'h01;
    step(1'b0);
    in = 7'h03;
    step(1'b0); step(1'b0);
    for (int k = 0; k < 3; k++) begin
      step(1'b1);
      chk_out("bounce_wait", 7'h01, 7'h00, 7'h00);
    end
    step(1'b1);
    chk_out("bounce_rise", 7'h03, 7'h02, 7'h00);
    step(1'b0);
    chk_out("bounce_after", 7'h03, 7'h00, 7'h00);

    // bypass channel 2: 3-clk latency, no ce needed
    csr_write(5'h1e, 8'h04);
    rd_check("bypass_rd", 5'h1e, 8'h04);
    in = 7'h07;
    step(1'b0); step(1'b0);
    chk_out("byp_wait", 7'h03, 7'h00, 7'h00);
    step(1'b0);
    chk_out("byp_rise", 7'h07, 7'h04, 7'h00);
    in = 7'h03;
    step(1'b0);
    chk_out("byp_after", 7'h07, 7'h00, 7'h00);
    step(1'b0); step(1'b0);
    chk_out("byp_fall", 7'h03, 7'h00, 7'h04);

    // TIME = 0 makes every channel unfiltered
    csr_write(5'h1d, 8'h00);
    in = 7'h0b;
    step(1'b0); step(1'b0);
    chk_out("t0_wait", 7'h03, 7'h00, 7'h00);
    step(1'b0);
    chk_out("t0_rise", 7'h0b, 7'h08, 7'h00);
    in = 7'h03;
    step(1'b0); step(1'b0); step(1'b0);
    chk_out("t0_fall", 7'h03, 7'h00, 7'h08);

    // TIME rewrite mid-count restarts channel 4
    csr_write(5'h1e, 8'h00);
    csr_write(5'h1d, 8'h08);
    in = 7'h13;
    step(1'b0); step(1'b0);
    for (int k = 0; k < 5; k++) step(1'b1);
    csr_write(5'h1d, 8'h08);
    for (int k = 0; k < 7; k++) step(1'b1);
    chk_out("rewrite_wait", 7'h03, 7'h00, 7'h00);
    step(1'b1);
    chk_out("rewrite_rise", 7'h13, 7'h10, 7'h00);
    step(1'b0);

    // asynchronous reset mid-count
    in = 7'h03;
    step(1'b0); step(1'b0);
    step(1'b1); step(1'b1); step(1'b1);
    rst = 1'b1;
    #1;
    chk_out("async_rst", 7'h00, 7'h00, 7'h00);
    rd_check("async_rst_time", 5'h1d, 8'h20);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step(1'b0);
      chk_out("post_rst", 7'h00, 7'h00, 7'h00);
    end

    // bus isolation
    for (int a = 0; a <= 28; a++) rd_check("iso_rd", 5'(a), 8'h00);
    rd_check("iso_rd_1f", 5'h1f, 8'h00);
    csr_write(5'h1c, 8'h55);
    rd_check("iso_time", 5'h1d, 8'h20);
    rd_check("iso_bypass", 5'h1e, 8'h00);
    csr_write(5'h1e, 8'hff);
    rd_check("bypass_mask", 5'h1e, 8'h7f);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gpi_debounce.md
Name: gpi_debounce

Overview:
- Multi-channel input debouncer for mechanical or noisy board inputs: power button, lid, force-recovery, charger signals.
- Sits between the input pins and the consumers in the top level: the power FSM, the GPI register block and the interrupt controller.
- Each channel is synchronised, then filtered with a per-channel stability counter clocked by a clock-enable. It outputs a clean level and single-cycle edge strobes.
- Debounce time and per-channel bypass are software-configurable through the shared 5-bit CSR bus.

Parameters:
- BASE_ADDR, 5'h1d, CSR address of the TIME register; the BYPASS register is at BASE_ADDR+1.
- NUM_INPUTS, 7, number of channels (1..8).
- DFL_STATE, {NUM_INPUTS{1'b0}}, reset level of the synchroniser flops and of out, per channel.
- DFL_TIME, 8'd32, reset value of TIME, counted in ce ticks (about 1 ms at 32 kHz).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- ce  in  1  single-cycle tick enable for the debounce counters (ce_32khz).
- csr_a  in  5  CSR address.
- csr_di  in  8  CSR write data.
- csr_we  in  1  CSR write strobe, one clk.
- csr_do  out  8  CSR read data; 8'h00 when not addressed, so it can be OR-combined onto the bus.
- in  in  NUM_INPUTS  raw asynchronous inputs, already polarity-corrected.
- out  out  NUM_INPUTS  debounced level.
- out_posedge  out  NUM_INPUTS  one-clk strobe on a 0->1 change of out.
- out_negedge  out  NUM_INPUTS  one-clk strobe on a 1->0 change of out.

Behaviour:
- Reset (asynchronous, rst high):
  - sync1, sync2 and out = DFL_STATE; strobes = 0.
  - All counters = 0; TIME = DFL_TIME; BYPASS = 0.
  - No edge strobe fires on reset release, even with inputs differing from DFL_STATE; the first change is filtered normally.
- Synchroniser: 2 flops per channel, in -> sync1 -> sync2. sync2 is the only value compared against out.
- Filter per channel, 8-bit counter cnt, evaluated each clk with this priority:
  1. CSR write to TIME: all cnt <= 0 and out holds.
  2. sync2 == out: cnt <= 0, regardless of ce.
  3. sync2 != out and ce and cnt == TIME-1: out <= sync2, cnt <= 0, matching strobe = 1.
  4. sync2 != out and ce: cnt <= cnt+1.
  5. Otherwise: hold.
- Net effect: out changes only after TIME consecutive ce ticks of stable mismatch. Any return to agreement, even for one clk, restarts the count.
- TIME == 0, or BYPASS[i] = 1:
  - Channel is unfiltered: out <= sync2 on every clk where they differ; strobe fires on that clk. cnt is held at 0.
  - Latency is 3 clk edges from a pin change to out.
- Strobes:
  - Registered and asserted in the same cycle out changes, for exactly one clk; 0 in all other cycles.
  - out_posedge and out_negedge are never both 1 for the same channel.
- Filtered latency: 2 clk of synchroniser, then TIME ce ticks; out updates on the clk edge carrying the TIME-th qualifying ce.
- Counter arithmetic:
  - Unsigned 8-bit. The count cannot exceed TIME-1, because the terminal condition resets it and a TIME write clears all counters, so no wrap-around occurs.
  - TIME = 255 gives the maximum of 255 ticks.
- CSR:
  - Reads are combinational from csr_a. BASE_ADDR returns TIME. BASE_ADDR+1 returns BYPASS zero-extended to 8 bits; unused bits read 0. All other addresses return 8'h00.
  - Writes take effect on the clk edge with csr_we high and a matching csr_a. BYPASS bits at and above NUM_INPUTS are ignored.
  - A BYPASS write does not clear counters. A newly bypassed channel follows sync2 from the next clk.
- Reset mid-count: counters and out return to reset values immediately (asynchronously); no strobe is emitted.

Test Plan:
- Reset check: assert rst with in = 7'h7f, then release → out = 0, all strobes 0, csr_do@1d = 8'h20, csr_do@1e = 8'h00. First rise of out follows 32 ce ticks, then one out_posedge pulse.
- Clean press: TIME = 4, in[0] 0->1 held → out[0] rises on the edge with the 4th ce after sync2 goes high; out_posedge[0] is high for exactly 1 clk; out_negedge stays 0.
- Bounce: TIME = 4, in[1] high for 3 ce ticks, low for 1 clk, high for 3 ticks → out[1] stays 0 and no strobes fire. Holding high for 4 more ticks gives a single rise.
- Bypass: write BYPASS = 8'h04, toggle in[2] → out[2] follows after 3 clk with one strobe per toggle. Write TIME = 0 and toggle in[3] → same behaviour.
- Mid-count events:
  - TIME = 8, in[4] high for 5 ticks, then write TIME = 8 again → count restarts; out[4] rises 8 ticks after the write.
  - Async rst pulse mid-count → out[4] = 0 immediately, no strobe.
- Bus isolation: reads at 5'h00..5'h1c and 5'h1f return 8'h00. A write at 5'h1c does not alter TIME or BYPASS.
